multi_cycle_cpu: RTL
====================

MULTI_CYCLE_CPU -- requirements
Module: multi_cycle_cpu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter NREG, default 32, register count; legal values 16 and 32.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-004 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_i  input  1  asynchronous, active-low reset.
REQ-006 imem_req_o  output  1  instruction fetch request.
REQ-007 imem_addr_o  output  XLEN  fetch address; equals pc_o.
REQ-008 imem_ack_i  input  1  fetch complete; imem_rdata_i valid in the same cycle.
REQ-009 imem_rdata_i  input  32  instruction word.
REQ-010 pc_o  output  XLEN  architectural PC.
REQ-011 retire_o  output  1  one-cycle pulse per completed instruction.
REQ-012 halt_o  output  1  sticky; high after an illegal instruction.

Function
REQ-013 SHALL implement the FSM states FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-014 FETCH: imem_req_o=1 and imem_addr_o held stable until imem_ack_i; on ack, latch the instruction into IR and go to DECODE; with no ack, stay in FETCH indefinitely.
REQ-015 DECODE: read rs1 (bits 19:15) and rs2 (bits 24:20) into operand registers A and B; form the sign-extended I or B immediate; go to EXECUTE, or to HALT if the opcode/funct is unsupported or any used register index is >= NREG.
REQ-016 EXECUTE: compute the ALU result into ALUOut; for branches, compute the taken flag and the target PC+immB; go to WRITEBACK.
REQ-017 WRITEBACK: write ALUOut to rd if the instruction writes and rd!=0; set PC to the branch target if taken, else PC+4; pulse retire_o; go to FETCH.
REQ-018 Supported R-type ops (opcode 0110011): ADD SUB SLL SLT SLTU XOR SRL SRA OR AND, selected by {funct7[5], funct3}.
REQ-019 Supported I-type ops (opcode 0010011): ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI.
REQ-020 Supported branch ops (opcode 1100011): BEQ, BNE; branches do not write a register.
REQ-021 Arithmetic SHALL wrap modulo 2^XLEN; there is no overflow trap.
REQ-022 Shift amount SHALL be the low log2(XLEN) bits of B or of the immediate.
REQ-023 SLT/SLTI SHALL compare signed; SLTU/SLTIU SHALL compare unsigned; result is 0 or 1, zero-extended.
REQ-024 x0 SHALL read as 0 always; writes to x0 are discarded.
REQ-025 Minimum latency SHALL be 4 cycles per instruction (ack in the first FETCH cycle); each extra wait cycle adds 1.
REQ-026 HALT: imem_req_o=0 and halt_o=1; PC frozen at the illegal instruction's address; no register writes; only reset exits.
REQ-027 PC SHALL wrap modulo 2^XLEN on increment and on branch target computation.

Reset
REQ-028 Asserting rst_i SHALL immediately force: state=FETCH, PC=RESET_PC, IR=0, A=B=ALUOut=0, all registers=0, retire_o=0, halt_o=0.
REQ-029 During reset, imem_req_o SHALL be 0; the first request SHALL be in the first clock edge cycle after rst_i deasserts.
REQ-030 Reset mid-instruction SHALL abandon the instruction without a register write or retire pulse; a pending ack is ignored.

Structure
REQ-031 Opcodes, funct encodings, the FSM state enum and ALU operation codes SHALL live in a shared package, cpu_pkg.
REQ-032 Register file SHALL be one sub-module, mc_reg_file (parameters XLEN, NREG; two combinational read ports; one synchronous write port); the ALU and FSM are inline.

Verification
REQ-033 ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 with ack every cycle -> x3=2; retire_o pulses at cycles 4, 8 and 12 after reset release.
REQ-034 x1=0x80000000 (XLEN=32): SRAI x4,x1,4 -> 0xF8000000; SRLI x5,x1,4 -> 0x08000000; SLTU x6,x0,x1 -> 1; SLT x7,x0,x1 -> 0.
REQ-035 BEQ x0,x0,+8 at PC=0x10 -> next imem_addr_o=0x18; BNE x0,x0,+8 -> 0x14; no register changes.
REQ-036 ADDI x0,x0,7 then ADD x1,x0,x0 -> x1=0; the x0 write is discarded.
REQ-037 Ack delayed 3 cycles -> imem_addr_o stable throughout, retire 7 cycles after the fetch starts; an undefined opcode 0x0000007F -> halt_o=1, imem_req_o=0, pc_o frozen.
REQ-038 rst_i asserted in EXECUTE of ADDI x1,x0,1 -> x1 stays 0, no retire pulse, first fetch after release at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle RV-subset core: opcodes, funct fields,
// FSM state codes and ALU operation codes.
package cpu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] ST_FETCH     = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_EXECUTE   = 3'd2;
    localparam logic [2:0] ST_WRITEBACK = 3'd3;
    localparam logic [2:0] ST_HALT      = 3'd4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // alt is funct7[5]; only meaningful for ADD/SUB and SRL/SRA
    function automatic alu_op_e alu_op_from_funct(input logic alt, input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_reg_file.sv
// Integer register file: two combinational read ports, one synchronous write
// port, x0 hard-wired to zero.
module mc_reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREG)-1:0]  raddr1,
    output logic [XLEN-1:0]          rdata1,
    input  logic [$clog2(NREG)-1:0]  raddr2,
    output logic [XLEN-1:0]          rdata2,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  waddr,
    input  logic [XLEN-1:0]          wdata
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs_r [NREG];

    // Register storage; writes to x0 are dropped so it always reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (we && (waddr != {AW{1'b0}})) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_r[raddr1];
    assign rdata2 = (raddr2 == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_r[raddr2];

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle RV32I/RV64I integer subset core (R-type ALU, I-type ALU, BEQ/BNE):
// FETCH -> DECODE -> EXECUTE -> WRITEBACK, with a sticky HALT on illegal code.
module multi_cycle_cpu
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [XLEN-1:0] pc_o,
    output logic            retire_o,
    output logic            halt_o
);
    localparam int AW = $clog2(NREG);
    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    logic [2:0]      state_r, state_nx_s;
    logic [XLEN-1:0] pc_r, a_r, b_r, imm_r, alu_out_r, target_r;
    logic [31:0]     ir_r;
    alu_op_e         alu_op_r, dec_op_s;
    logic            use_imm_r, writes_r, is_branch_r, branch_ne_r, taken_r;
    logic            req_r, retire_r, halt_r;

    logic [6:0]      opc_s, f7_s, shfun_s;
    logic [2:0]      f3_s;
    logic [4:0]      rs1_s, rs2_s, rd_s;
    logic            legal_s, uses_rs2_s, uses_rd_s, dec_use_imm_s, dec_branch_s;
    logic            regs_ok_s, dec_ok_s, we_s;
    logic [XLEN-1:0] imm_i_s, imm_b_s, rs1_data_s, rs2_data_s, op_b_s, alu_s;
    logic [SW-1:0]   shamt_s;

    assign opc_s = ir_r[6:0];
    assign rd_s  = ir_r[11:7];
    assign f3_s  = ir_r[14:12];
    assign rs1_s = ir_r[19:15];
    assign rs2_s = ir_r[24:20];
    assign f7_s  = ir_r[31:25];
    // RV64 shift immediates use bit 25 as shamt[5], so only bits 31:26 are funct
    assign shfun_s = (XLEN == 64) ? {ir_r[31:26], 1'b0} : ir_r[31:25];

    assign imm_i_s = {{(XLEN-12){ir_r[31]}}, ir_r[31:20]};
    assign imm_b_s = {{(XLEN-13){ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};

    // Instruction decode and legality check
    always_comb begin
        legal_s       = 1'b0;
        uses_rs2_s    = 1'b0;
        uses_rd_s     = 1'b0;
        dec_use_imm_s = 1'b0;
        dec_branch_s  = 1'b0;
        dec_op_s      = ALU_ADD;
        case (opc_s)
            OPC_OP: begin
                uses_rs2_s = 1'b1;
                uses_rd_s  = 1'b1;
                dec_op_s   = alu_op_from_funct(f7_s[5], f3_s);
                if (f7_s == F7_BASE) begin
                    legal_s = 1'b1;
                end else if ((f7_s == F7_ALT) && ((f3_s == F3_ADD) || (f3_s == F3_SR))) begin
                    legal_s = 1'b1;
                end else begin
                    legal_s = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                uses_rd_s     = 1'b1;
                dec_use_imm_s = 1'b1;
                if (f3_s == F3_SLL) begin
                    dec_op_s = ALU_SLL;
                    legal_s  = (shfun_s == F7_BASE);
                end else if (f3_s == F3_SR) begin
                    dec_op_s = shfun_s[5] ? ALU_SRA : ALU_SRL;
                    legal_s  = (shfun_s == F7_BASE) || (shfun_s == F7_ALT);
                end else begin
                    dec_op_s = alu_op_from_funct(1'b0, f3_s);
                    legal_s  = 1'b1;
                end
            end
            OPC_BRANCH: begin
                uses_rs2_s   = 1'b1;
                dec_branch_s = 1'b1;
                legal_s      = (f3_s == F3_BEQ) || (f3_s == F3_BNE);
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    assign regs_ok_s = (int'(rs1_s) < NREG)
                    && (!uses_rs2_s || (int'(rs2_s) < NREG))
                    && (!uses_rd_s  || (int'(rd_s)  < NREG));
    assign dec_ok_s  = legal_s && regs_ok_s;

    assign we_s = (state_r == ST_WRITEBACK) && writes_r;

    mc_reg_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .raddr1 (rs1_s[AW-1:0]),
        .rdata1 (rs1_data_s),
        .raddr2 (rs2_s[AW-1:0]),
        .rdata2 (rs2_data_s),
        .we     (we_s),
        .waddr  (rd_s[AW-1:0]),
        .wdata  (alu_out_r)
    );

    assign op_b_s  = use_imm_r ? imm_r : b_r;
    assign shamt_s = op_b_s[SW-1:0];

    // ALU on latched operands
    always_comb begin
        alu_s = ZERO;
        case (alu_op_r)
            ALU_ADD:  alu_s = a_r + op_b_s;
            ALU_SUB:  alu_s = a_r - op_b_s;
            ALU_SLL:  alu_s = a_r << shamt_s;
            ALU_SLT:  alu_s = {{(XLEN-1){1'b0}}, ($signed(a_r) < $signed(op_b_s))};
            ALU_SLTU: alu_s = {{(XLEN-1){1'b0}}, (a_r < op_b_s)};
            ALU_XOR:  alu_s = a_r ^ op_b_s;
            ALU_SRL:  alu_s = a_r >> shamt_s;
            ALU_SRA:  alu_s = $signed(a_r) >>> shamt_s;
            ALU_OR:   alu_s = a_r | op_b_s;
            ALU_AND:  alu_s = a_r & op_b_s;
            default:  alu_s = ZERO;
        endcase
    end

    // Next-state logic; a fetch only completes while the request is visible
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_FETCH:     state_nx_s = (req_r && imem_ack_i) ? ST_DECODE : ST_FETCH;
            ST_DECODE:    state_nx_s = dec_ok_s ? ST_EXECUTE : ST_HALT;
            ST_EXECUTE:   state_nx_s = ST_WRITEBACK;
            ST_WRITEBACK: state_nx_s = ST_FETCH;
            ST_HALT:      state_nx_s = ST_HALT;
            default:      state_nx_s = ST_HALT;
        endcase
    end

    // Architectural and pipeline-step registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= ST_FETCH;
            pc_r        <= RESET_PC;
            ir_r        <= 32'd0;
            a_r         <= ZERO;
            b_r         <= ZERO;
            imm_r       <= ZERO;
            alu_out_r   <= ZERO;
            target_r    <= ZERO;
            alu_op_r    <= ALU_ADD;
            use_imm_r   <= 1'b0;
            writes_r    <= 1'b0;
            is_branch_r <= 1'b0;
            branch_ne_r <= 1'b0;
            taken_r     <= 1'b0;
            req_r       <= 1'b0;
            retire_r    <= 1'b0;
            halt_r      <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            req_r    <= (state_nx_s == ST_FETCH);
            retire_r <= (state_nx_s == ST_WRITEBACK);
            halt_r   <= halt_r | (state_nx_s == ST_HALT);
            case (state_r)
                ST_FETCH: begin
                    if (req_r && imem_ack_i) begin
                        ir_r <= imem_rdata_i;
                    end
                end
                ST_DECODE: begin
                    a_r         <= rs1_data_s;
                    b_r         <= rs2_data_s;
                    imm_r       <= dec_branch_s ? imm_b_s : imm_i_s;
                    alu_op_r    <= dec_op_s;
                    use_imm_r   <= dec_use_imm_s;
                    writes_r    <= uses_rd_s;
                    is_branch_r <= dec_branch_s;
                    branch_ne_r <= f3_s[0];
                end
                ST_EXECUTE: begin
                    alu_out_r <= alu_s;
                    taken_r   <= is_branch_r && (branch_ne_r ? (a_r != b_r) : (a_r == b_r));
                    target_r  <= pc_r + imm_r;
                end
                ST_WRITEBACK: begin
                    pc_r <= taken_r ? target_r : (pc_r + PC_STEP);
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_req_o  = req_r;
    assign imem_addr_o = pc_r;
    assign pc_o        = pc_r;
    assign retire_o    = retire_r;
    assign halt_o      = halt_r;

endmodule
